// File: rtl/clz_pkg.sv
// Shared types and helpers for the iterative leading-zero/one counter.
package clz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } clz_state_e;

  localparam logic CLZ_MODE_ZEROS = 1'b0;
  localparam logic CLZ_MODE_ONES  = 1'b1;

  // True when WIDTH is a power of two >= 2 and RES_W can hold 0..WIDTH.
  function automatic bit clz_width_ok(int unsigned width, int unsigned res_w);
    bit pow2;
    pow2 = (width >= 2) && ((width & (width - 1)) == 0);
    return pow2 && (res_w >= $clog2(width) + 1);
  endfunction

endpackage

// File: rtl/clz_iter_unit.sv
// Multi-cycle CLZ/CLO unit: binary-search shifter, one halving step per clock.
module clz_iter_unit
  import clz_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] out,
  output logic             all_same
);

  localparam int unsigned L  = $clog2(WIDTH);
  localparam int unsigned CW = L + 1;
  localparam int unsigned SW = (L > 1) ? $clog2(L) : 1;

  if (!clz_width_ok(WIDTH, RES_W)) begin : g_bad_param
    $error("clz_iter_unit: WIDTH must be a power of 2 >= 2 and RES_W >= clog2(WIDTH)+1");
  end

  clz_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] out_q, out_d;
  logic             all_same_q, all_same_d;

  // One search step: skip h zero MSBs if present; on the last step count the surviving MSB.
  function automatic logic [WIDTH+CW-1:0] clz_step(input logic [WIDTH-1:0] x_in,
                                                   input logic [CW-1:0]    c_in,
                                                   input logic [SW-1:0]    s);
    int unsigned      h;
    logic [WIDTH-1:0] top_mask;
    logic [WIDTH-1:0] x_out;
    logic [CW-1:0]    c_out;
    h        = 32'd1 << s;
    top_mask = ~({WIDTH{1'b1}} >> h);
    x_out    = x_in;
    c_out    = c_in;
    if ((x_in & top_mask) == '0) begin
      c_out = c_in + CW'(h);
      x_out = x_in << h;
    end
    if ((s == '0) && !x_out[WIDTH-1]) begin
      c_out = c_out + CW'(1);
    end
    return {x_out, c_out};
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      all_same_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_q      <= out_d;
      all_same_q <= all_same_d;
    end
  end

  // Next-state, datapath step and registered-output values.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    out_d      = out_q;
    all_same_d = all_same_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_d     = (mode == CLZ_MODE_ONES) ? ~in : in;
          cnt_d   = '0;
          step_d  = SW'(L - 1);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        {x_d, cnt_d} = clz_step(x_q, cnt_q, step_q);
        if (step_q == '0) begin
          out_d      = RES_W'(cnt_d);
          all_same_d = (cnt_d == CW'(WIDTH));
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          step_d = step_q - SW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign all_same = all_same_q;

endmodule

// File: tb/tb_clz_iter_unit.sv
// Directed and reference-model checks for clz_iter_unit at WIDTH=32 and WIDTH=8.
module tb_clz_iter_unit;

  logic        clk;
  logic        rst;
  logic        start, mode;
  logic [31:0] din;
  logic        busy, done, all_same;
  logic [31:0] dout;

  logic        start8, mode8;
  logic [7:0]  din8;
  logic        busy8, done8, all_same8;
  logic [3:0]  dout8;

  int total = 0;
  int bad   = 0;

  clz_iter_unit #(.WIDTH(32), .RES_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in(din),
    .busy(busy), .done(done), .out(dout), .all_same(all_same)
  );

  clz_iter_unit #(.WIDTH(8), .RES_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .in(din8),
    .busy(busy8), .done(done8), .out(dout8), .all_same(all_same8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] v;
    logic [31:0] exp_out;
    logic        exp_same;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan from the MSB for the first bit that differs from the counted value.
  function automatic logic [31:0] ref_count(input logic m, input logic [31:0] v);
    logic [31:0] n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] != m) break;
      n++;
    end
    return n;
  endfunction

  // One operation on the 32-bit unit; lat = edges from the accepting edge (1) to done.
  task automatic run32(input logic m, input logic [31:0] v, output logic [31:0] o,
                       output logic s, output int lat, output int bcnt);
    mode = m; din = v; start = 1'b1;
    lat = 0; bcnt = 0; o = '0; s = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1) begin
        start = 1'b0; din = 32'hDEAD_BEEF; mode = ~m;
      end
      if (done) begin
        lat = e; o = dout; s = all_same;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic run8(input logic m, input logic [7:0] v, output logic [31:0] o,
                      output logic s, output int lat, output int bcnt);
    mode8 = m; din8 = v; start8 = 1'b1;
    lat = 0; bcnt = 0; o = '0; s = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1) begin
        start8 = 1'b0; din8 = 8'hA5;
      end
      if (done8) begin
        lat = e; o = 32'(dout8); s = all_same8;
        break;
      end
      if (busy8) bcnt++;
    end
  endtask

  initial begin
    vec_t        vecs [12];
    vec_t        vecs8[6];
    logic [31:0] o;
    logic        s;
    int          lat, bcnt, ndone;
    int          e1, e2;
    logic [31:0] o1, o2;

    vecs[0]  = '{1'b0, 32'h8000_0000, 32'd0,  1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0001, 32'd31, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'd32, 1'b1};
    vecs[3]  = '{1'b1, 32'hFFF0_0000, 32'd12, 1'b0};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'd32, 1'b1};
    vecs[5]  = '{1'b1, 32'h7FFF_FFFF, 32'd0,  1'b0};
    vecs[6]  = '{1'b0, 32'h00FF_0000, 32'd8,  1'b0};
    vecs[7]  = '{1'b0, 32'h0000_8000, 32'd16, 1'b0};
    vecs[8]  = '{1'b0, 32'h0F00_0000, 32'd4,  1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0000, 32'd1,  1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFFE, 32'd31, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0003, 32'd30, 1'b0};

    vecs8[0] = '{1'b0, 32'h00, 32'd8, 1'b1};
    vecs8[1] = '{1'b0, 32'h10, 32'd3, 1'b0};
    vecs8[2] = '{1'b0, 32'h80, 32'd0, 1'b0};
    vecs8[3] = '{1'b0, 32'h01, 32'd7, 1'b0};
    vecs8[4] = '{1'b1, 32'hFF, 32'd8, 1'b1};
    vecs8[5] = '{1'b1, 32'hF0, 32'd4, 1'b0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; din = '0;
    start8 = 1'b0; mode8 = 1'b0; din8 = '0;
    tick(); tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", dout, 32'd0);
    check("reset all_same", 32'(all_same), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven directed vectors, 32-bit.
    foreach (vecs[i]) begin
      run32(vecs[i].m, vecs[i].v, o, s, lat, bcnt);
      check($sformatf("v32[%0d] out", i), o, vecs[i].exp_out);
      check($sformatf("v32[%0d] all_same", i), 32'(s), 32'(vecs[i].exp_same));
      check($sformatf("v32[%0d] latency", i), 32'(lat), 32'd6);
      check($sformatf("v32[%0d] busy cycles", i), 32'(bcnt), 32'd5);
      tick();
      check($sformatf("v32[%0d] done width", i), 32'(done), 32'd0);
    end

    // Table-driven directed vectors, 8-bit.
    foreach (vecs8[i]) begin
      run8(vecs8[i].m, vecs8[i].v[7:0], o, s, lat, bcnt);
      check($sformatf("v8[%0d] out", i), o, vecs8[i].exp_out);
      check($sformatf("v8[%0d] all_same", i), 32'(s), 32'(vecs8[i].exp_same));
      check($sformatf("v8[%0d] latency", i), 32'(lat), 32'd4);
      check($sformatf("v8[%0d] busy cycles", i), 32'(bcnt), 32'd3);
      tick();
    end

    // start pulses during RUN are ignored.
    mode = 1'b0; din = 32'h0000_0100; start = 1'b1;
    ndone = 0; o = '0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      start = ((e == 2) || (e == 4)) ? 1'b1 : 1'b0;
      din   = 32'hFFFF_FFFF;
      if (done) begin
        ndone++; o = dout;
      end
    end
    check("run-start out", o, 32'd23);
    check("run-start done count", 32'(ndone), 32'd1);

    // start held high: back-to-back operations accepted from DONE.
    mode = 1'b0; din = 32'h00FF_0000; start = 1'b1;
    e1 = 0; e2 = 0; o1 = '0; o2 = '0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (done) begin
        if (e1 == 0) begin
          e1 = e; o1 = dout; din = 32'h0000_8000;
        end else if (e2 == 0) begin
          e2 = e; o2 = dout; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b first edge", 32'(e1), 32'd6);
    check("b2b first out", o1, 32'd8);
    check("b2b second edge", 32'(e2), 32'd12);
    check("b2b second out", o2, 32'd16);
    tick();

    // Asynchronous reset mid-RUN discards the count.
    run32(1'b0, 32'h0000_0000, o, s, lat, bcnt);
    check("pre-reset all_same", 32'(s), 32'd1);
    mode = 1'b0; din = 32'h0000_0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst out", dout, 32'd0);
    check("async rst all_same", 32'(all_same), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (done) ndone++;
    end
    check("post-rst no done", 32'(ndone), 32'd0);
    run32(1'b0, 32'h0001_0000, o, s, lat, bcnt);
    check("post-rst out", o, 32'd15);
    check("post-rst latency", 32'(lat), 32'd6);
    tick();

    // Random sweep against the scan model, both modes, varied leading-run lengths.
    for (int i = 0; i < 3000; i++) begin
      logic        m;
      logic [31:0] v;
      m = 1'($urandom_range(1, 0));
      v = $urandom() >> $urandom_range(32, 0);
      if (m) v = ~v;
      run32(m, v, o, s, lat, bcnt);
      if (o !== ref_count(m, v) || lat != 6)
        check($sformatf("rand m=%0d v=%h", m, v), o, ref_count(m, v));
      else
        total++;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
